load_store_unit: RTL and testbench

- Initiator side of the data_memory port: sits in the MEM stage between the pipeline and data_memory.
- Accepts one load/store request at a time.
- Word loads/stores go straight through to memory. Byte/half loads are extracted from the read word and sign- or zero-extended.
- Byte/half stores are done as read-modify-write, because data_memory has only a whole-word i_we and no byte enables.
- Misaligned and out-of-range requests are flagged and never reach memory.

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used by the request error check.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package load_store_unit_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_ST_IDLE  = 2'd0,
    LSU_ST_READ  = 2'd1,
    LSU_ST_WRITE = 2'd2,
    LSU_ST_RESP  = 2'd3
  } lsu_state_e;

  // Illegal size, odd half address or non-word-aligned word address.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) ||
           (size == LSU_SIZE_H && lo[0]) ||
           (size == LSU_SIZE_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses: extends a loaded byte/half and builds
// the merged word for read-modify-write stores.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [`DATA_WIDTH-1:0] word,
  input  logic [1:0]             addr_lo,
  input  logic [1:0]             size,
  input  logic                   is_unsigned,
  input  logic [`DATA_WIDTH-1:0] wdata,
  output logic [`DATA_WIDTH-1:0] load_data,
  output logic [`DATA_WIDTH-1:0] merge_data
);

  logic [`DATA_WIDTH-1:0] lane;
  assign lane = word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = word;
    case (size)
      LSU_SIZE_B: load_data = {{(`DATA_WIDTH-8){~is_unsigned & lane[7]}}, lane[7:0]};
      LSU_SIZE_H: load_data = {{(`DATA_WIDTH-16){~is_unsigned & lane[15]}}, lane[15:0]};
      default:    load_data = word;
    endcase
  end

  // Each byte lane either keeps the old memory byte or takes the store byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      always_comb begin
        hit = 1'b1;
        src = wdata[8*gi +: 8];
        case (size)
          LSU_SIZE_B: begin
            hit = (addr_lo == LANE);
            src = wdata[7:0];
          end
          LSU_SIZE_H: begin
            hit = (addr_lo[1] == LANE[1]);
            src = LANE[0] ? wdata[15:8] : wdata[7:0];
          end
          default: begin
            hit = 1'b1;
            src = wdata[8*gi +: 8];
          end
        endcase
      end

      assign merge_data[8*gi +: 8] = hit ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for data_memory: one request at a time, sub-word loads
// extracted from the read word, sub-word stores done as read-modify-write.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [1:0]             i_req_size,
  input  logic                   i_req_unsigned,
  input  logic [31:0]            i_req_addr,
  input  logic [`DATA_WIDTH-1:0] i_req_wdata,
  output logic                   o_rsp_valid,
  output logic [`DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic                   o_mem_we,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [`DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [`DATA_WIDTH-1:0] i_mem_rdata
);

  lsu_state_e             state_reg, state_next;
  logic [1:0]             size_reg;
  logic [1:0]             lo_reg;
  logic                   uns_reg;
  logic                   we_reg;
  logic                   accept;
  logic                   req_err;
  logic [`DATA_WIDTH-1:0] load_data;
  logic [`DATA_WIDTH-1:0] merge_data;

  assign o_req_ready = (state_reg == LSU_ST_IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;
  assign req_err     = lsu_misaligned(i_req_size, i_req_addr[1:0]) ||
                       (i_req_addr >= 32'(MEM_SIZE));
  assign o_mem_we    = (state_reg == LSU_ST_WRITE) && !i_rst;
  assign o_rsp_valid = (state_reg == LSU_ST_RESP) && !i_rst;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_ST_IDLE: begin
        if (accept) begin
          if (req_err)
            state_next = LSU_ST_RESP;
          else if (i_req_we && i_req_size == LSU_SIZE_W)
            state_next = LSU_ST_WRITE;
          else
            state_next = LSU_ST_READ;
        end
      end
      LSU_ST_READ:  state_next = we_reg ? LSU_ST_WRITE : LSU_ST_RESP;
      LSU_ST_WRITE: state_next = LSU_ST_RESP;
      default:      state_next = LSU_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= LSU_ST_IDLE;
    else       state_reg <= state_next;
  end

  // Response registers only change on the edge that enters RESP, so they
  // hold the previous result while the next request is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      size_reg    <= '0;
      lo_reg      <= '0;
      uns_reg     <= 1'b0;
      we_reg      <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state_reg)
        LSU_ST_IDLE: begin
          if (accept) begin
            size_reg <= i_req_size;
            lo_reg   <= i_req_addr[1:0];
            uns_reg  <= i_req_unsigned;
            we_reg   <= i_req_we;
            if (req_err) begin
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else begin
              o_mem_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
              if (i_req_we) o_mem_wdata <= i_req_wdata;
            end
          end
        end
        LSU_ST_READ: begin
          if (we_reg) begin
            o_mem_wdata <= merge_data;
          end else begin
            o_rsp_rdata <= load_data;
            o_rsp_err   <= 1'b0;
          end
        end
        LSU_ST_WRITE: begin
          o_rsp_rdata <= '0;
          o_rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Store data held in o_mem_wdata during READ is the merge source.
  lsu_align u_align (
    .word        (i_mem_rdata),
    .addr_lo     (lo_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .wdata       (o_mem_wdata),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data_memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } rsp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          cyc;
    string       name;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.MEM_SIZE(1024)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]   = 32'h87654321;
    mem[255] = 32'hA5000000;
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge. Latencies count from the accept edge.
  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int rsp_lat,
                       input int wr_lat, input logic [31:0] exp_wdata);
    int   n;
    int   ea;
    rsp_t r;
    wr_t  w;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wdata;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      check({name, " ready_timeout"}, 32'(ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    ea = cyc + 1;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    r.cyc   = ea + rsp_lat - 1;
    r.name  = name;
    rsp_q.push_back(r);
    if (wr_lat > 0) begin
      w.addr  = {addr[9:2], 2'b00};
      w.wdata = exp_wdata;
      w.cyc   = ea + wr_lat - 1;
      w.name  = name;
      wr_q.push_back(w);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    $display("req  %-10s we=%b size=%b uns=%b addr=%h wdata=%h accepted at edge %0d",
             name, we, size, uns, addr, wdata, ea);
  endtask

  // Monitor: pops expected responses and memory writes as the DUT shows them.
  initial begin
    rsp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got response rdata=%h err=%b at %0d, expected none",
                   rsp_rdata, rsp_err, cyc);
        end else begin
          e = rsp_q.pop_front();
          check({e.name, " rdata"}, rsp_rdata, e.rdata);
          check({e.name, " err"}, 32'(rsp_err), 32'(e.err));
          check({e.name, " rsp_cycle"}, 32'(cyc), 32'(e.cyc));
          $display("rsp  %-10s rdata=%h err=%b cycle=%0d", e.name, rsp_rdata, rsp_err, cyc);
        end
      end
      if (mem_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write addr=%h data=%h at %0d, expected none",
                   mem_addr, mem_wdata, cyc);
        end else begin
          w = wr_q.pop_front();
          check({w.name, " wr_addr"}, 32'(mem_addr), 32'(w.addr));
          check({w.name, " wr_data"}, mem_wdata, w.wdata);
          check({w.name, " wr_cycle"}, 32'(cyc), 32'(w.cyc));
          $display("wr   %-10s addr=%h data=%h cycle=%0d", w.name, mem_addr, mem_wdata, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_uns   = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'hFFFFFFFF;

    // Reset held with a request pending.
    @(negedge clk);
    @(negedge clk);
    check("rst rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'h0);
    check("rst mem_we", 32'(mem_we), 32'h0);
    check("rst mem_addr", 32'(mem_addr), 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst ready", 32'(ready), 32'h0);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_rst ready", 32'(ready), 32'h1);
    @(negedge clk);

    // name, we, size, uns, addr, wdata, exp_rdata, exp_err, rsp_lat, wr_lat, exp_wdata
    issue("LW_10",   1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h87654321, 1'b0, 2, 0, 32'h0);
    issue("LB_13",   1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFF87, 1'b0, 2, 0, 32'h0);
    issue("LBU_13",  1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'h00000087, 1'b0, 2, 0, 32'h0);
    issue("LH_12",   1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'hFFFF8765, 1'b0, 2, 0, 32'h0);
    issue("LHU_10",  1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        32'h00004321, 1'b0, 2, 0, 32'h0);
    issue("LBU_3FF", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0,        32'h000000A5, 1'b0, 2, 0, 32'h0);
    issue("LB_3FF",  1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 0, 32'h0);
    issue("SB_11",   1'b1, 2'b00, 1'b0, 32'h11,  32'h123456AA, 32'h0,        1'b0, 3, 2, 32'h8765AA21);
    issue("SW_14",   1'b1, 2'b10, 1'b0, 32'h14,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF);
    issue("LW_10b",  1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h8765AA21, 1'b0, 2, 0, 32'h0);
    issue("LW_14",   1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
    issue("SH_16",   1'b1, 2'b01, 1'b0, 32'h16,  32'h00001234, 32'h0,        1'b0, 3, 2, 32'h1234BEEF);
    issue("ERR_LW12",  1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
    issue("ERR_SH11",  1'b1, 2'b01, 1'b0, 32'h11,  32'h5555,     32'h0, 1'b1, 1, 0, 32'h0);
    issue("ERR_LW400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
    issue("ERR_SZ11",  1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
    issue("LW_14b",  1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'h1234BEEF, 1'b0, 2, 0, 32'h0);

    // Reset landing in the WRITE cycle of a half store must not commit.
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort ready_before", 32'(ready), 32'h1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b01;
    req_uns   = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0000BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort mem_we", 32'(mem_we), 32'h0);
    check("abort rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check("abort ready_in_rst", 32'(ready), 32'h0);
    rst = 1'b0;
    #1;
    check("abort ready_after", 32'(ready), 32'h1);
    check("abort mem_10", mem[4], 32'h8765AA21);
    $display("req  SH_10_abort reset during WRITE, no response expected");
    @(negedge clk);
    issue("LW_10c",  1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h8765AA21, 1'b0, 2, 0, 32'h0);

    n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain rsp_q", 32'(rsp_q.size()), 32'h0);
    check("drain wr_q", 32'(wr_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
